// File: rtl/set_assoc_tag_array_if.sv
// set_assoc_tag_array_if
//   Bundles the request, write, flush and response signals of the
//   set-associative tag store.
//   master : cache controller side; drives requests, writes and flush_req.
//   slave  : tag store side; drives the registered response, busy and flush_done.
//   Ports carried:
//     req_valid, index, tag_in                    (lookup request)
//     replace_tag, replace_way, valid_in, dirty_in (tag install)
//     mark_dirty, mark_way                        (store-hit dirty set)
//     flush_req                                   (invalidate-all start)
//     rsp_valid, hit, hit_way, dirty,
//     victim_way, victim_tag                      (lookup response)
//     busy, flush_done                            (flush status)
//   Optional macro TAG_PARITY_EN adds parity_err to the response.
interface set_assoc_tag_array_if #(
  parameter int IDX  = 10,
  parameter int TAG  = 11,
  parameter int WAYS = 4
);
  localparam int WW = $clog2(WAYS);

  logic           req_valid;
  logic [IDX-1:0] index;
  logic [TAG-1:0] tag_in;
  logic           rsp_valid;
  logic           hit;
  logic [WW-1:0]  hit_way;
  logic           dirty;
  logic [WW-1:0]  victim_way;
  logic [TAG-1:0] victim_tag;
  logic           replace_tag;
  logic [WW-1:0]  replace_way;
  logic           valid_in;
  logic           dirty_in;
  logic           mark_dirty;
  logic [WW-1:0]  mark_way;
  logic           flush_req;
  logic           busy;
  logic           flush_done;
`ifdef TAG_PARITY_EN
  logic           parity_err;

  modport master (
    output req_valid, index, tag_in, replace_tag, replace_way, valid_in,
           dirty_in, mark_dirty, mark_way, flush_req,
    input  rsp_valid, hit, hit_way, dirty, victim_way, victim_tag, busy,
           flush_done, parity_err
  );
  modport slave (
    input  req_valid, index, tag_in, replace_tag, replace_way, valid_in,
           dirty_in, mark_dirty, mark_way, flush_req,
    output rsp_valid, hit, hit_way, dirty, victim_way, victim_tag, busy,
           flush_done, parity_err
  );
`else
  modport master (
    output req_valid, index, tag_in, replace_tag, replace_way, valid_in,
           dirty_in, mark_dirty, mark_way, flush_req,
    input  rsp_valid, hit, hit_way, dirty, victim_way, victim_tag, busy,
           flush_done
  );
  modport slave (
    input  req_valid, index, tag_in, replace_tag, replace_way, valid_in,
           dirty_in, mark_dirty, mark_way, flush_req,
    output rsp_valid, hit, hit_way, dirty, victim_way, victim_tag, busy,
           flush_done
  );
`endif
endinterface

// File: rtl/set_assoc_tag_array.sv
// set_assoc_tag_array
//   N-way set-associative tag store for the L1 data cache. Registered
//   lookup (1-cycle) with hit-way and victim selection, tree pseudo-LRU per
//   set, per-way dirty bits and a one-set-per-cycle flush engine.
//   Ports:
//     clk  - clock
//     rst  - asynchronous, active-high reset (valid/dirty/PLRU/FSM/outputs)
//     bus  - set_assoc_tag_array_if.slave (requests, writes, flush, response)
//   Optional macro TAG_PARITY_EN: per-entry even parity bit, parity_err
//   response output, parity-failing ways forced to miss.
module set_assoc_tag_array #(
  parameter int IDX  = 10,
  parameter int TAG  = 11,
  parameter int WAYS = 4
) (
  input  logic                clk,
  input  logic                rst,
  set_assoc_tag_array_if.slave bus
);
  localparam int WW   = $clog2(WAYS);
  localparam int SETS = 2 ** IDX;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                     r_state, w_state_nxt;
  logic [IDX-1:0]             r_cnt;
  logic                       r_flush_done, w_done_nxt, w_busy;

  logic [TAG-1:0]             r_tag [SETS][WAYS];
  logic [SETS-1:0][WAYS-1:0]  r_valid, r_dirty;
  logic [SETS-1:0][WAYS-2:0]  r_plru;

  logic                       w_req;
  logic [WAYS-1:0]            w_set_valid, w_set_dirty, w_match;
  logic                       w_hit, w_any_inv;
  logic [WW-1:0]              w_hit_way, w_inv_way, w_victim;

  logic                       r_rsp_valid, r_hit, r_dirty_o;
  logic [WW-1:0]              r_hit_way, r_victim_way;
  logic [TAG-1:0]             r_victim_tag;
`ifdef TAG_PARITY_EN
  logic [SETS-1:0][WAYS-1:0]  r_par;
  logic [WAYS-1:0]            w_par_fail;
  logic                       r_parity_err;
`endif

  // Heap-ordered tree (node n at bit n-1); the root splits on the way LSB.
  // Each node bit names the child subtree to victimise next.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] p,
                                                 input logic [WW-1:0] way);
    logic [WAYS-2:0] q;
    logic [WW-1:0]   n;
    q = p;
    n = WW'(1);
    for (int unsigned l = 0; l < WW; l++) begin
      q[n - 1'b1] = ~way[l];
      n = (n << 1) | WW'(way[l]);
    end
    return q;
  endfunction

  function automatic logic [WW-1:0] plru_victim(input logic [WAYS-2:0] p);
    logic [WW-1:0] n, v;
    n = WW'(1);
    v = '0;
    for (int unsigned l = 0; l < WW; l++) begin
      v[l] = p[n - 1'b1];
      n = (n << 1) | WW'(v[l]);
    end
    return v;
  endfunction

  // Flush FSM
  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_busy      = (r_state == FLUSH);
    case (r_state)
      IDLE:  if (bus.flush_req) w_state_nxt = FLUSH;
      FLUSH: if (&r_cnt) begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_flush_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_done <= w_done_nxt;
      r_cnt        <= (r_state == FLUSH) ? r_cnt + 1'b1 : '0;
    end
  end

  // Lookup (combinational on current contents, registered below)
  assign w_req       = bus.req_valid & ~w_busy;
  assign w_set_valid = r_valid[bus.index];
  assign w_set_dirty = r_dirty[bus.index];

  always_comb begin
    w_match   = '0;
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_any_inv = 1'b0;
    w_inv_way = '0;
`ifdef TAG_PARITY_EN
    w_par_fail = '0;
`endif
    for (int unsigned i = 0; i < WAYS; i++) begin
`ifdef TAG_PARITY_EN
      w_par_fail[i] = w_set_valid[i] & (^r_tag[bus.index][i] ^ r_par[bus.index][i]);
      w_match[i]    = w_set_valid[i] & ~w_par_fail[i] & (r_tag[bus.index][i] == bus.tag_in);
`else
      w_match[i]    = w_set_valid[i] & (r_tag[bus.index][i] == bus.tag_in);
`endif
    end
    // Scan high to low so the lowest matching / invalid way is left standing.
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (w_match[WAYS-1-i]) begin
        w_hit     = 1'b1;
        w_hit_way = WW'(WAYS-1-i);
      end
      if (!w_set_valid[WAYS-1-i]) begin
        w_any_inv = 1'b1;
        w_inv_way = WW'(WAYS-1-i);
      end
    end
  end

  assign w_victim = w_any_inv ? w_inv_way : plru_victim(r_plru[bus.index]);

  // State arrays. Statement order encodes priority: replace_tag overrides
  // both mark_dirty and the lookup-hit PLRU update on the same index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
      r_plru  <= '0;
    end else if (w_busy) begin
      r_valid[r_cnt] <= '0;
      r_dirty[r_cnt] <= '0;
      r_plru[r_cnt]  <= '0;
    end else begin
      if (w_req && w_hit)
        r_plru[bus.index] <= plru_touch(r_plru[bus.index], w_hit_way);
      if (bus.mark_dirty)
        r_dirty[bus.index][bus.mark_way] <= 1'b1;
      if (bus.replace_tag) begin
        r_valid[bus.index][bus.replace_way] <= bus.valid_in;
        r_dirty[bus.index][bus.replace_way] <= bus.dirty_in;
        r_plru[bus.index] <= plru_touch(r_plru[bus.index], bus.replace_way);
      end
    end
  end

  // Tag contents are not reset.
  always_ff @(posedge clk) begin
    if (!w_busy && bus.replace_tag) begin
      r_tag[bus.index][bus.replace_way] <= bus.tag_in;
`ifdef TAG_PARITY_EN
      r_par[bus.index][bus.replace_way] <= ^bus.tag_in;
`endif
    end
  end

  // Registered response; fields hold when no request is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid  <= 1'b0;
      r_hit        <= 1'b0;
      r_hit_way    <= '0;
      r_dirty_o    <= 1'b0;
      r_victim_way <= '0;
      r_victim_tag <= '0;
`ifdef TAG_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= w_req;
      if (w_req) begin
        r_hit        <= w_hit;
        r_hit_way    <= w_hit_way;
        r_dirty_o    <= w_set_dirty[w_hit ? w_hit_way : w_victim];
        r_victim_way <= w_victim;
        r_victim_tag <= r_tag[bus.index][w_victim];
`ifdef TAG_PARITY_EN
        r_parity_err <= |w_par_fail;
`endif
      end
    end
  end

  assign bus.rsp_valid  = r_rsp_valid;
  assign bus.hit        = r_hit;
  assign bus.hit_way    = r_hit_way;
  assign bus.dirty      = r_dirty_o;
  assign bus.victim_way = r_victim_way;
  assign bus.victim_tag = r_victim_tag;
  assign bus.busy       = w_busy;
  assign bus.flush_done = r_flush_done;
`ifdef TAG_PARITY_EN
  assign bus.parity_err = r_parity_err;
`endif
endmodule

// File: tb/tb_set_assoc_tag_array.sv
module tb_set_assoc_tag_array;
  localparam int IDX  = 4;
  localparam int TAG  = 11;
  localparam int WAYS = 4;
  localparam int WW   = 2;
  localparam int SETS = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;
  bit   armed = 0;

  set_assoc_tag_array_if #(.IDX(IDX), .TAG(TAG), .WAYS(WAYS)) bus ();
  set_assoc_tag_array #(.IDX(IDX), .TAG(TAG), .WAYS(WAYS)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: plain arrays; PLRU kept as a table keyed by
  // (depth, low address bits of the way) holding the side to evict.
  bit m_valid [SETS][WAYS];
  bit m_dirty [SETS][WAYS];
  bit m_wr    [SETS][WAYS];
  int m_tag   [SETS][WAYS];
  bit m_vic   [SETS][WW][WAYS/2];
  int m_left = 0;

  bit e_rsp = 0, e_hit = 0, e_dirty = 0, e_busy = 0, e_done = 0, e_vtk = 1;
  int e_hw = 0, e_vw = 0, e_vt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0;
        m_dirty[s][w] = 0;
      end
    for (int s = 0; s < SETS; s++)
      for (int d = 0; d < WW; d++)
        for (int k = 0; k < WAYS/2; k++) m_vic[s][d][k] = 0;
  endtask

  task automatic m_touch(input int s, input int w);
    for (int d = 0; d < WW; d++)
      m_vic[s][d][w & ((1 << d) - 1)] = !((w >> d) & 1);
  endtask

  function automatic int m_victim(input int s);
    int p = 0;
    for (int d = 0; d < WW; d++) p = p | (int'(m_vic[s][d][p]) << d);
    return p;
  endfunction

  always @(posedge clk or posedge rst) begin
    int s, hw, vw;
    bit h;
    if (rst) begin
      m_clear();
      m_left = 0;
      e_rsp = 0; e_hit = 0; e_dirty = 0; e_done = 0;
      e_hw = 0; e_vw = 0; e_vt = 0; e_vtk = 1;
    end else if (m_left > 0) begin
      e_rsp = 0;
      e_done = 0;
      m_left--;
      if (m_left == 0) begin
        m_clear();
        e_done = 1;
      end
    end else begin
      e_rsp = 0;
      e_done = 0;
      s = int'(bus.index);
      h = 0; hw = 0;
      if (bus.req_valid) begin
        for (int w = WAYS-1; w >= 0; w--)
          if (m_valid[s][w] && m_tag[s][w] == int'(bus.tag_in)) begin h = 1; hw = w; end
        vw = -1;
        for (int w = WAYS-1; w >= 0; w--) if (!m_valid[s][w]) vw = w;
        if (vw < 0) vw = m_victim(s);
        e_rsp = 1; e_hit = h; e_hw = hw; e_vw = vw;
        e_dirty = h ? m_dirty[s][hw] : m_dirty[s][vw];
        e_vt = m_tag[s][vw];
        e_vtk = m_wr[s][vw];
        if (h && !bus.replace_tag) m_touch(s, hw);
      end
      if (bus.mark_dirty) m_dirty[s][int'(bus.mark_way)] = 1;
      if (bus.replace_tag) begin
        m_valid[s][int'(bus.replace_way)] = bus.valid_in;
        m_dirty[s][int'(bus.replace_way)] = bus.dirty_in;
        m_tag[s][int'(bus.replace_way)]   = int'(bus.tag_in);
        m_wr[s][int'(bus.replace_way)]    = 1;
        m_touch(s, int'(bus.replace_way));
      end
      if (bus.flush_req) m_left = SETS;
    end
    e_busy = (m_left > 0);
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("rsp_valid", bus.rsp_valid, e_rsp);
      chk("hit", bus.hit, e_hit);
      chk("hit_way", bus.hit_way, e_hw);
      chk("dirty", bus.dirty, e_dirty);
      chk("victim_way", bus.victim_way, e_vw);
      if (e_vtk) chk("victim_tag", bus.victim_tag, e_vt);
      chk("busy", bus.busy, e_busy);
      chk("flush_done", bus.flush_done, e_done);
`ifdef TAG_PARITY_EN
      chk("parity_err", bus.parity_err, 0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    bus.req_valid = 0; bus.index = '0; bus.tag_in = '0;
    bus.replace_tag = 0; bus.replace_way = '0; bus.valid_in = 0; bus.dirty_in = 0;
    bus.mark_dirty = 0; bus.mark_way = '0; bus.flush_req = 0;
  endtask

  task automatic lookup(input int s, input int t);
    bus.req_valid = 1; bus.index = IDX'(s); bus.tag_in = TAG'(t);
    step();
    bus.req_valid = 0;
  endtask

  task automatic replace(input int s, input int w, input int t, input bit v, input bit d);
    bus.replace_tag = 1; bus.index = IDX'(s); bus.replace_way = WW'(w);
    bus.tag_in = TAG'(t); bus.valid_in = v; bus.dirty_in = d;
    step();
    bus.replace_tag = 0;
  endtask

  task automatic mark(input int s, input int w);
    bus.mark_dirty = 1; bus.index = IDX'(s); bus.mark_way = WW'(w);
    step();
    bus.mark_dirty = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nd;
    idle_in();
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #2 rst = 0;
    armed = 1;

    // Cold lookup
    lookup(5, 'h1A);
    chk("cold_rsp", bus.rsp_valid, 1);
    chk("cold_hit", bus.hit, 0);
    chk("cold_victim", bus.victim_way, 0);
    chk("cold_dirty", bus.dirty, 0);
    step();
    chk("rsp_drop", bus.rsp_valid, 0);

    // Install, hit, mark dirty
    replace(5, 2, 'h1A, 1, 0);
    lookup(5, 'h1A);
    chk("inst_hit", bus.hit, 1);
    chk("inst_way", bus.hit_way, 2);
    mark(5, 2);
    lookup(5, 'h1A);
    chk("mark_dirty", bus.dirty, 1);

    // replace_tag beats mark_dirty on the same way
    bus.mark_dirty = 1; bus.mark_way = 2'd2;
    replace(5, 2, 'h1A, 1, 0);
    bus.mark_dirty = 0;
    lookup(5, 'h1A);
    chk("rep_over_mark", bus.dirty, 0);

    // PLRU: fill, hit 0,1,2 -> victim 3; hit 3 -> victim 0
    for (int w = 0; w < 4; w++) replace(7, w, 'h10 + w, 1, 0);
    for (int w = 0; w < 3; w++) lookup(7, 'h10 + w);
    lookup(7, 'h7FF);
    chk("plru_v3", bus.victim_way, 3);
    chk("plru_v3_tag", bus.victim_tag, 'h13);
    lookup(7, 'h13);
    chk("hit_w3", bus.hit_way, 3);
    lookup(7, 'h7FF);
    chk("plru_v0", bus.victim_way, 0);
    chk("plru_v0_tag", bus.victim_tag, 'h10);

    // Same-cycle lookup and replace sees old contents
    bus.req_valid = 1;
    replace(9, 1, 'h55, 1, 0);
    bus.req_valid = 0;
    chk("rbw_miss", bus.hit, 0);
    lookup(9, 'h55);
    chk("rbw_hit", bus.hit, 1);
    chk("rbw_way", bus.hit_way, 1);

    // Flush with requests attempted while busy
    replace(3, 0, 'h22, 1, 1);
    bus.flush_req = 1;
    step();
    bus.flush_req = 0;
    nb = 0; nd = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.busy) nb++;
      if (bus.flush_done) nd++;
      if (i < 4) begin
        bus.req_valid = 1; bus.index = 4'd3; bus.tag_in = 11'h22;
        bus.replace_tag = 1; bus.replace_way = 2'd1; bus.valid_in = 1;
        bus.mark_dirty = 1; bus.mark_way = 2'd0;
        bus.flush_req = (i > 0);
      end else idle_in();
      step();
    end
    chk("flush_busy_cycles", nb, 16);
    chk("flush_done_pulses", nd, 1);
    lookup(5, 'h1A);
    chk("post_flush_hit5", bus.hit, 0);
    lookup(7, 'h12);
    chk("post_flush_hit7", bus.hit, 0);
    lookup(3, 'h22);
    chk("post_flush_hit3", bus.hit, 0);
    chk("post_flush_dirty3", bus.dirty, 0);

    // Reset in the middle of a flush (counter = 6)
    replace(2, 0, 'h33, 1, 1);
    bus.flush_req = 1;
    step();
    bus.flush_req = 0;
    repeat (6) step();
    rst = 1;
    #1;
    chk("rst_busy", bus.busy, 0);
    nd = 0;
    step();
    rst = 0;
    for (int i = 0; i < 30; i++) begin
      if (bus.flush_done) nd++;
      step();
    end
    chk("rst_no_done", nd, 0);
    lookup(2, 'h33);
    chk("rst_hit", bus.hit, 0);
    chk("rst_dirty", bus.dirty, 0);

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/set_assoc_tag_array.md
Name: set_assoc_tag_array

Overview:
N-way set-associative tag store for the L1 data cache. It is the successor to the direct-mapped tag store. It performs a registered lookup with hit-way and victim selection, keeps tree pseudo-LRU state per set, tracks dirty bits per way, and provides a sequential flush engine that invalidates every set without asserting reset. It sits between the cache controller FSM and the data array, which is indexed by {index, way}.

Parameters:
IDX, 10, index width; SETS = 2**IDX
TAG, 11, tag width
WAYS, 4, associativity; power of 2, >= 2
WW, $clog2(WAYS), way-number width (derived, not overridable)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  1  lookup request
index  in  IDX  set index (lookup, replace and mark_dirty)
tag_in  in  TAG  lookup tag / tag to install
rsp_valid  out  1  registered lookup response valid
hit  out  1  lookup hit
hit_way  out  WW  way that hit (0 on miss)
dirty  out  1  dirty bit of hit way, or of victim way on miss
victim_way  out  WW  way to replace on miss
victim_tag  out  TAG  tag currently held in victim_way (for write-back address)
replace_tag  in  1  install {valid_in, tag_in, dirty_in} into index/replace_way
replace_way  in  WW  target way for replace_tag
valid_in  in  1  valid bit to install
dirty_in  in  1  dirty bit to install
mark_dirty  in  1  set dirty bit of index/mark_way (store hit)
mark_way  in  WW  way for mark_dirty
flush_req  in  1  start invalidate-all
busy  out  1  flush in progress
flush_done  out  1  one-cycle pulse when flush completes

Behaviour:
- Reset: all valid, dirty and PLRU bits = 0; FSM to IDLE. All outputs = 0. Tag contents undefined. Reset during a flush aborts it with no flush_done.
- Lookup, 1-cycle latency: req_valid sampled at edge N; at edge N+1 rsp_valid=1 and the hit/way/dirty/victim outputs describe state as of before edge N. Without a new request, rsp_valid=0 and the other outputs hold.
- hit = OR over ways of (valid[w] && tag[w]==tag_in). Multiple matches are illegal; the lowest way wins.
- victim_way = lowest-index invalid way if any, else tree-PLRU victim. victim_tag/dirty come from that way.
- PLRU: WAYS-1 bits per set. Updated at the sampling edge to point away from the accessed way on a lookup hit and on replace_tag. A miss leaves it unchanged.
- Write ports are applied at the edge. Read-before-write: a lookup in the same cycle as a write to the same index sees old contents and old PLRU.
- replace_tag and mark_dirty on the same index and way in the same cycle: replace_tag wins.
- replace_tag and lookup hit on the same index in the same cycle: the PLRU update from replace_tag wins.
- Flush FSM, states IDLE -> FLUSH -> IDLE:
  - flush_req in IDLE: busy=1 from the next cycle; counter starts at 0.
  - Each FLUSH cycle clears valid, dirty and PLRU of set[counter]; one set per cycle, SETS cycles total.
  - After the last set: busy=0 and flush_done=1 for exactly one cycle.
- While busy=1: req_valid, replace_tag, mark_dirty and flush_req are ignored; rsp_valid stays 0.

Optional Feature:
TAG_PARITY_EN
- Defined: one even-parity bit is stored per tag entry, written on replace_tag. Adds output parity_err (1 bit), registered with the response. It is 1 if any valid way in the looked-up set fails parity. A way failing parity is forced to miss.
- Undefined: no parity storage, no parity_err port, behaviour exactly as above.

Test Plan:
- Reset, then lookup index=5, tag=0x1A -> next cycle rsp_valid=1, hit=0, victim_way=0, dirty=0.
- replace index=5 way=2 tag=0x1A valid=1 dirty=0, then lookup 0x1A -> hit=1, hit_way=2; mark_dirty way 2, relookup -> dirty=1.
- Fill index=7 ways 0..3 with tags 0x10..0x13, then hit ways 0,1,2 in order -> victim_way=3; hit way 3 -> victim_way=0.
- Same-cycle lookup and replace at index=9 way 1 tag=0x55 -> first response hit=0; next lookup hit=1, hit_way=1.
- Fill several sets, flush_req with IDX=4 -> busy=1 for 16 cycles, flush_done pulses once, requests ignored meanwhile; all later lookups miss with dirty=0.
- Assert rst mid-flush at counter=6 -> busy=0 immediately, flush_done never pulses, all lookups miss.
